// File: rtl/ysyx_23060208_isram.sv
// AXI4-Lite read-only instruction SRAM responder with optional delay injection.
// Ports: clk/rst, isram AR/R channel (responder side), sync backing memory read port.
module ysyx_23060208_isram #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                    MEM_WORDS   = 65536,
  parameter int                    RAND_DELAY  = 1,
  parameter int                    FIXED_DELAY = 0,
  parameter int                    DLY_BITS    = 3,
  parameter logic [7:0]            LFSR_SEED   = 8'h5A,
  localparam int                   AW          = $clog2(MEM_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] isram_araddr,
  input  logic                  isram_arvalid,
  output logic                  isram_arready,
  output logic [DATA_WIDTH-1:0] isram_rdata,
  output logic                  isram_rvalid,
  output logic [1:0]            isram_rresp,
  input  logic                  isram_rready,
  output logic                  mem_ren,
  output logic [AW-1:0]         mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    RD,
    LATCH,
    RESP
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  localparam logic [7:0] SEED =
    (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  // One extra bit keeps BASE_ADDR + span from wrapping.
  localparam logic [DATA_WIDTH:0] BASE_X = {1'b0, BASE_ADDR};
  localparam logic [DATA_WIDTH:0] SPAN =
    (DATA_WIDTH+1)'(MEM_WORDS) << 2;
  localparam logic [DATA_WIDTH:0] LIM = BASE_X + SPAN;

  state_t state, nxt;

  logic [DATA_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] addr_off;
  logic                  err_r;
  logic                  err_in;
  logic [DLY_BITS-1:0]   cnt;
  logic [DLY_BITS-1:0]   dly;
  logic [7:0]            lfsr;
  logic                  lfsr_fb;
  logic                  ar_hs;
  logic                  r_hs;
  logic                  err_enter;

  function automatic logic addr_err(
    input logic [DATA_WIDTH-1:0] a
  );
    logic [DATA_WIDTH:0] ax;
    ax = {1'b0, a};
    return (a[1:0] != 2'b00) || (ax < BASE_X) || (ax >= LIM);
  endfunction

  assign isram_arready = (state == IDLE) && !rst;
  assign isram_rvalid  = (state == RESP);

  assign ar_hs  = isram_arvalid && isram_arready;
  assign r_hs   = isram_rvalid && isram_rready;
  assign err_in = addr_err(isram_araddr);

  // Delay is sampled on the same edge that accepts the address.
  assign dly = (RAND_DELAY != 0) ? lfsr[DLY_BITS-1:0]
                                 : DLY_BITS'(FIXED_DELAY);

  // x^8+x^6+x^5+x^4+1, shifting toward the MSB.
  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  assign addr_off  = addr_r - BASE_ADDR;
  assign mem_raddr = AW'(addr_off >> 2);

  // Errors skip the memory and go straight to the response.
  assign err_enter = (nxt == RESP) &&
                     ((state == IDLE) || (state == DELAY));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt     = state;
    mem_ren = 1'b0;
    unique case (state)
      IDLE: begin
        if (ar_hs) begin
          if (dly == '0) begin
            nxt = err_in ? RESP : RD;
          end else begin
            nxt = DELAY;
          end
        end
      end
      DELAY: begin
        if (cnt == '0) begin
          nxt = err_r ? RESP : RD;
        end
      end
      RD: begin
        mem_ren = 1'b1;
        nxt     = LATCH;
      end
      LATCH: begin
        nxt = RESP;
      end
      RESP: begin
        if (r_hs) begin
          nxt = IDLE;
        end
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr        <= SEED;
      cnt         <= '0;
      addr_r      <= '0;
      err_r       <= 1'b0;
      isram_rdata <= '0;
      isram_rresp <= OKAY;
    end else begin
      lfsr <= {lfsr[6:0], lfsr_fb};
      if (ar_hs) begin
        addr_r <= isram_araddr;
        err_r  <= err_in;
        if (dly != '0) begin
          cnt <= dly - 1'b1;
        end
      end
      if ((state == DELAY) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (state == LATCH) begin
        isram_rdata <= mem_rdata;
        isram_rresp <= OKAY;
      end
      if (err_enter) begin
        isram_rdata <= '0;
        isram_rresp <= SLVERR;
      end
    end
  end

endmodule
